// File: rtl/thread_lsu_if.sv
// Memory-side valid/ready port of the per-thread load/store unit.
// The master drives the requests and the slave (memory controller) answers them.
interface thread_lsu_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/thread_lsu.sv
// Per-thread load/store unit. It issues one memory access per REQUEST phase, holds
// the result until UPDATE, and aborts an access that waits too long.
module thread_lsu #(
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [3:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    thread_lsu_if.master         mem,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);
    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } state_e;

    localparam logic [3:0]  CORE_REQUEST = 4'b0100;
    localparam logic [3:0]  CORE_UPDATE  = 4'b0111;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic                 is_read_q, is_read_d;
    logic [15:0]          count_q, count_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic [DATA_BITS-1:0] lsu_out_q, lsu_out_d;
    logic                 lsu_error_q, lsu_error_d;
    logic                 active_ready;

    always_comb begin
        state_d      = state_q;
        is_read_d    = is_read_q;
        count_d      = count_q;
        rd_valid_d   = rd_valid_q;
        rd_addr_d    = rd_addr_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        lsu_out_d    = lsu_out_q;
        lsu_error_d  = lsu_error_q;
        active_ready = is_read_q ? mem.mem_read_ready : mem.mem_write_ready;

        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        state_d     = REQUESTING;
                        // Read wins when both are decoded; the choice is latched here.
                        is_read_d   = decoded_mem_read_enable;
                        lsu_error_d = 1'b0;
                    end
                end
                REQUESTING: begin
                    count_d = '0;
                    state_d = WAITING;
                    if (is_read_q) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rs[ADDR_BITS-1:0];
                    end else begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = rs[ADDR_BITS-1:0];
                        wr_data_d  = rt;
                    end
                end
                WAITING: begin
                    if (active_ready) begin
                        rd_valid_d = 1'b0;
                        wr_valid_d = 1'b0;
                        if (is_read_q) lsu_out_d = mem.mem_read_data;
                        state_d = DONE;
                    end else if (TIMEOUT_EN && count_q == TIMEOUT_LAST) begin
                        rd_valid_d  = 1'b0;
                        wr_valid_d  = 1'b0;
                        lsu_error_d = 1'b1;
                        if (is_read_q) lsu_out_d = '0;
                        state_d = DONE;
                    end else if (count_q != '1) begin
                        count_d = count_q + 16'd1;
                    end
                end
                DONE: begin
                    if (core_state == CORE_UPDATE) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            is_read_q   <= 1'b0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            rd_addr_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            lsu_out_q   <= '0;
            lsu_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_read_q   <= is_read_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_q   <= rd_addr_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            lsu_out_q   <= lsu_out_d;
            lsu_error_q <= lsu_error_d;
        end
    end

    assign mem.mem_read_valid    = rd_valid_q;
    assign mem.mem_read_address  = rd_addr_q;
    assign mem.mem_write_valid   = wr_valid_q;
    assign mem.mem_write_address = wr_addr_q;
    assign mem.mem_write_data    = wr_data_q;
    assign lsu_state             = state_q;
    assign lsu_out               = lsu_out_q;
    assign lsu_error             = lsu_error_q;
endmodule

// File: tb/tb_thread_lsu.sv
// Bench for thread_lsu: directed accesses push expected completions into a queue,
// and a negedge monitor checks each completion plus the request it observed.
module tb_thread_lsu;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] core_state;
    logic       rd_en;
    logic       wr_en;
    logic [7:0] rs;
    logic [7:0] rt;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       lsu_error;

    thread_lsu_if #(.ADDR_BITS(8), .DATA_BITS(8)) mif ();

    thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .core_state              (core_state),
        .decoded_mem_read_enable (rd_en),
        .decoded_mem_write_enable(wr_en),
        .rs                      (rs),
        .rt                      (rt),
        .mem                     (mif.master),
        .lsu_state               (lsu_state),
        .lsu_out                 (lsu_out),
        .lsu_error               (lsu_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_read;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] out;
        bit         err;
        int         cycles;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: accumulates what the request port did and checks it when DONE is entered.
    int         mon_cyc = 0;
    bit         mon_rseen = 0;
    bit         mon_wseen = 0;
    logic [7:0] cap_addr;
    logic [7:0] cap_data;
    logic [1:0] prev_state = 2'b00;

    always @(negedge clk) begin
        if (reset) begin
            mon_cyc = 0; mon_rseen = 0; mon_wseen = 0; prev_state = 2'b00;
        end else begin
            if (mif.mem_read_valid || mif.mem_write_valid) begin
                if (mon_cyc == 0) begin
                    cap_addr = mif.mem_read_valid ? mif.mem_read_address : mif.mem_write_address;
                    cap_data = mif.mem_write_data;
                end else begin
                    chk("addr_stable", mif.mem_read_valid ? mif.mem_read_address
                                                          : mif.mem_write_address, cap_addr);
                    if (mif.mem_write_valid) chk("wdata_stable", mif.mem_write_data, cap_data);
                end
                mon_cyc++;
                if (mif.mem_read_valid)  mon_rseen = 1;
                if (mif.mem_write_valid) mon_wseen = 1;
            end
            if (lsu_state == 2'b11 && prev_state != 2'b11) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("lsu_out", lsu_out, e.out);
                    chk("lsu_error", lsu_error, e.err);
                    chk("valid_cycles", mon_cyc, e.cycles);
                    chk("address", cap_addr, e.addr);
                    if (!e.is_read) chk("write_data", cap_data, e.data);
                    chk("read_channel", mon_rseen, e.is_read);
                    chk("write_channel", mon_wseen, !e.is_read);
                end
                mon_cyc = 0; mon_rseen = 0; mon_wseen = 0;
            end
            prev_state = lsu_state;
        end
    end

    // delay<0: ready never comes. other_ready drives the inactive channel's ready.
    task automatic run_op(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rdata, input int delay, input bit other_ready);
        exp_t e;
        bit   is_rd;
        bit   tmo;
        is_rd     = rd;
        tmo       = (delay < 0);
        e.is_read = is_rd;
        e.addr    = a;
        e.data    = d;
        e.err     = tmo;
        e.cycles  = tmo ? TO : delay + 1;
        if (is_rd) model_out = tmo ? 8'h00 : rdata;
        e.out     = model_out;
        sb.push_back(e);

        mif.mem_read_data = rdata;
        rs = a; rt = d; rd_en = rd; wr_en = wr;
        core_state = 4'b0100;
        step();
        chk("requesting", lsu_state, 2'b01);
        chk("error_cleared", lsu_error, 1'b0);
        core_state = 4'b0101;
        step();
        chk("valid_rise", is_rd ? mif.mem_read_valid : mif.mem_write_valid, 1'b1);
        rd_en = 1'b0; wr_en = 1'b0;
        for (int k = 0; k < 40 && lsu_state != 2'b11; k++) begin
            mif.mem_read_ready  = is_rd ? (k == delay) : other_ready;
            mif.mem_write_ready = is_rd ? other_ready : (k == delay);
            step();
        end
        mif.mem_read_ready = 1'b0; mif.mem_write_ready = 1'b0;
        chk("reach_done", lsu_state, 2'b11);
        step(); step();
        chk("done_hold", lsu_state, 2'b11);
        chk("done_out", lsu_out, model_out);
        core_state = 4'b0111;
        step();
        chk("back_idle", lsu_state, 2'b00);
        chk("update_out", lsu_out, model_out);
        core_state = 4'b0000;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int steps;
        exp_t e;
        reset = 1'b1; enable = 1'b1; core_state = 4'b0000;
        rd_en = 1'b0; wr_en = 1'b0; rs = 8'h00; rt = 8'h00;
        mif.mem_read_ready = 1'b0; mif.mem_write_ready = 1'b0; mif.mem_read_data = 8'h00;
        model_out = 8'h00;
        step(); step();
        chk("rst_state", lsu_state, 2'b00);
        chk("rst_rvalid", mif.mem_read_valid, 1'b0);
        chk("rst_wvalid", mif.mem_write_valid, 1'b0);
        chk("rst_out", lsu_out, 8'h00);
        chk("rst_err", lsu_error, 1'b0);
        chk("rst_waddr", mif.mem_write_address, 8'h00);
        reset = 1'b0;
        step();

        run_op(1'b1, 1'b0, 8'h2A, 8'h00, 8'h5C, 0, 1'b0);   // load, earliest completion
        run_op(1'b0, 1'b1, 8'h10, 8'hAB, 8'h00, 3, 1'b0);   // store, ready on last-chance cycle
        run_op(1'b1, 1'b0, 8'h33, 8'h00, 8'h99, -1, 1'b0);  // load timeout
        run_op(1'b1, 1'b1, 8'h44, 8'h12, 8'hC3, 2, 1'b1);   // both enables, write ready ignored
        run_op(1'b0, 1'b1, 8'h55, 8'h66, 8'h00, -1, 1'b0);  // store timeout keeps lsu_out

        // Reset while WAITING
        rs = 8'h21; rd_en = 1'b1; core_state = 4'b0100;
        step();
        core_state = 4'b0101; rd_en = 1'b0;
        step(); step(); step();
        chk("pre_reset_valid", mif.mem_read_valid, 1'b1);
        reset = 1'b1;
        step();
        chk("midrst_valid", mif.mem_read_valid, 1'b0);
        chk("midrst_state", lsu_state, 2'b00);
        chk("midrst_out", lsu_out, 8'h00);
        chk("midrst_addr", mif.mem_read_address, 8'h00);
        reset = 1'b0; model_out = 8'h00; core_state = 4'b0000;
        step();

        // enable=0 for 5 cycles in WAITING: ready ignored, counter frozen
        e.is_read = 1'b1; e.addr = 8'h3C; e.data = 8'h00; e.out = 8'h00; e.err = 1'b1;
        e.cycles = 9;
        sb.push_back(e);
        rs = 8'h3C; rd_en = 1'b1; mif.mem_read_data = 8'h77; core_state = 4'b0100;
        step();
        core_state = 4'b0101; rd_en = 1'b0;
        step();
        step();
        enable = 1'b0; mif.mem_read_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_state", lsu_state, 2'b10);
            chk("frz_valid", mif.mem_read_valid, 1'b1);
            chk("frz_addr", mif.mem_read_address, 8'h3C);
        end
        enable = 1'b1; mif.mem_read_ready = 1'b0;
        steps = 0;
        while (lsu_state != 2'b11 && steps < 20) begin
            step();
            steps++;
        end
        chk("frz_resume_cycles", steps, 3);
        core_state = 4'b0111;
        step();
        core_state = 4'b0000;
        step();

        run_op(1'b1, 1'b0, 8'h7F, 8'h00, 8'hE1, 1, 1'b0);   // load after timeout
        step(); step();
        chk("queue_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
